// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - four-digit BCD MM:SS up/down counter with wrap/saturate ends
// Run-time digit adjust is built only when BCD_TIME_COUNTER_ADJUST_EN is defined.
module bcd_time_counter #(
    parameter int unsigned MIN_TENS_MAX = 5,
    parameter bit          WRAP         = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       paused,
    input  logic       dir,
    input  logic       adj_load,
    input  logic [1:0] adj_sel,
    input  logic [3:0] adj_val,
    output logic [3:0] min_l,
    output logic [3:0] min_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_r,
    output logic       carry_out,
    output logic       expired,
    output logic       at_limit
);
    localparam logic [3:0] ML_MAX = 4'(MIN_TENS_MAX);

    logic [3:0] min_l_nxt;
    logic [3:0] min_r_nxt;
    logic [3:0] sec_l_nxt;
    logic [3:0] sec_r_nxt;
    logic       carry_nxt;
    logic       expired_nxt;
    logic       at_limit_nxt;
    logic       step;
    logic       adj_take;
    logic       at_full;
    logic       at_zero;

    assign step    = tick & ~paused;
    assign at_zero = (min_l == 4'd0) && (min_r == 4'd0) && (sec_l == 4'd0) && (sec_r == 4'd0);
    assign at_full = (min_l == ML_MAX) && (min_r == 4'd9) && (sec_l == 4'd5) && (sec_r == 4'd9);

`ifdef BCD_TIME_COUNTER_ADJUST_EN
    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign adj_take = adj_load;
`else
    logic unused_adj;
    assign unused_adj = ^{adj_load, adj_sel, adj_val};
    assign adj_take   = 1'b0;
`endif

    always_comb begin
        min_l_nxt    = min_l;
        min_r_nxt    = min_r;
        sec_l_nxt    = sec_l;
        sec_r_nxt    = sec_r;
        carry_nxt    = 1'b0;
        expired_nxt  = 1'b0;
        at_limit_nxt = at_limit;
        if (adj_take) begin
`ifdef BCD_TIME_COUNTER_ADJUST_EN
            // An adjust wins over a same-cycle tick; the tick is simply lost.
            case (adj_sel)
                2'd0:    min_l_nxt = clamp(adj_val, ML_MAX);
                2'd1:    min_r_nxt = clamp(adj_val, 4'd9);
                2'd2:    sec_l_nxt = clamp(adj_val, 4'd5);
                default: sec_r_nxt = clamp(adj_val, 4'd9);
            endcase
            at_limit_nxt = 1'b0;
`endif
        end else if (step) begin
            if (!dir) begin
                if (at_full) begin
                    if (WRAP) begin
                        min_l_nxt    = 4'd0;
                        min_r_nxt    = 4'd0;
                        sec_l_nxt    = 4'd0;
                        sec_r_nxt    = 4'd0;
                        carry_nxt    = 1'b1;
                        at_limit_nxt = 1'b0;
                    end else begin
                        at_limit_nxt = 1'b1;
                    end
                end else begin
                    at_limit_nxt = 1'b0;
                    if (sec_r != 4'd9) begin
                        sec_r_nxt = sec_r + 4'd1;
                    end else begin
                        sec_r_nxt = 4'd0;
                        if (sec_l != 4'd5) begin
                            sec_l_nxt = sec_l + 4'd1;
                        end else begin
                            sec_l_nxt = 4'd0;
                            if (min_r != 4'd9) begin
                                min_r_nxt = min_r + 4'd1;
                            end else begin
                                min_r_nxt = 4'd0;
                                min_l_nxt = min_l + 4'd1;
                            end
                        end
                    end
                end
            end else begin
                if (at_zero) begin
                    if (WRAP) begin
                        min_l_nxt    = ML_MAX;
                        min_r_nxt    = 4'd9;
                        sec_l_nxt    = 4'd5;
                        sec_r_nxt    = 4'd9;
                        carry_nxt    = 1'b1;
                        at_limit_nxt = 1'b0;
                    end else begin
                        at_limit_nxt = 1'b1;
                    end
                end else begin
                    at_limit_nxt = 1'b0;
                    expired_nxt  = (min_l == 4'd0) && (min_r == 4'd0) &&
                                   (sec_l == 4'd0) && (sec_r == 4'd1);
                    if (sec_r != 4'd0) begin
                        sec_r_nxt = sec_r - 4'd1;
                    end else begin
                        sec_r_nxt = 4'd9;
                        if (sec_l != 4'd0) begin
                            sec_l_nxt = sec_l - 4'd1;
                        end else begin
                            sec_l_nxt = 4'd5;
                            if (min_r != 4'd0) begin
                                min_r_nxt = min_r - 4'd1;
                            end else begin
                                min_r_nxt = 4'd9;
                                min_l_nxt = min_l - 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_l     <= 4'd0;
            min_r     <= 4'd0;
            sec_l     <= 4'd0;
            sec_r     <= 4'd0;
            carry_out <= 1'b0;
            expired   <= 1'b0;
            at_limit  <= 1'b0;
        end else begin
            min_l     <= min_l_nxt;
            min_r     <= min_r_nxt;
            sec_l     <= sec_l_nxt;
            sec_r     <= sec_r_nxt;
            carry_out <= carry_nxt;
            expired   <= expired_nxt;
            at_limit  <= at_limit_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - scoreboard bench for bcd_time_counter (wrap and saturate builds)
module tb_bcd_time_counter;
`ifdef BCD_TIME_COUNTER_ADJUST_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       paused = 1'b0;
    logic       dir = 1'b0;
    logic       adj_load = 1'b0;
    logic [1:0] adj_sel = 2'd0;
    logic [3:0] adj_val = 4'd0;

    logic [3:0] w_ml, w_mr, w_sl, w_sr;
    logic       w_cy, w_ex, w_lim;
    logic [3:0] s_ml, s_mr, s_sl, s_sr;
    logic       s_cy, s_ex, s_lim;

    int checks = 0;
    int failures = 0;
    int ms[2];
    bit mlim[2];
    int mtm_of[2] = '{5, 2};
    bit wrap_of[2] = '{1'b1, 1'b0};
    logic [18:0] q_w[$];
    logic [18:0] q_s[$];

    always #5 clk = ~clk;

    bcd_time_counter u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .paused(paused), .dir(dir),
        .adj_load(adj_load), .adj_sel(adj_sel), .adj_val(adj_val),
        .min_l(w_ml), .min_r(w_mr), .sec_l(w_sl), .sec_r(w_sr),
        .carry_out(w_cy), .expired(w_ex), .at_limit(w_lim)
    );

    bcd_time_counter #(.MIN_TENS_MAX(2), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .paused(paused), .dir(dir),
        .adj_load(adj_load), .adj_sel(adj_sel), .adj_val(adj_val),
        .min_l(s_ml), .min_r(s_mr), .sec_l(s_sl), .sec_r(s_sr),
        .carry_out(s_cy), .expired(s_ex), .at_limit(s_lim)
    );

    // Reference model keeps the count as plain seconds 0..full.
    function automatic void model_step(input int s, input bit lim, input int mtm, input bit wrap,
                                       input bit tk, input bit pz, input bit dr, input bit al,
                                       input logic [1:0] sel, input logic [3:0] val,
                                       output int ns, output bit nlim, output bit cy, output bit ex);
        int full;
        int d[4];
        int mx[4];
        full = mtm * 600 + 599;
        ns = s; nlim = lim; cy = 1'b0; ex = 1'b0;
        if (ADJ && al) begin
            d[0] = s / 600; d[1] = (s / 60) % 10; d[2] = (s % 60) / 10; d[3] = s % 10;
            mx[0] = mtm; mx[1] = 9; mx[2] = 5; mx[3] = 9;
            d[sel] = (int'(val) > mx[sel]) ? mx[sel] : int'(val);
            ns = d[0] * 600 + d[1] * 60 + d[2] * 10 + d[3];
            nlim = 1'b0;
        end else if (tk && !pz) begin
            if (!dr) begin
                if (s == full) begin
                    if (wrap) begin ns = 0; cy = 1'b1; nlim = 1'b0; end
                    else nlim = 1'b1;
                end else begin
                    ns = s + 1; nlim = 1'b0;
                end
            end else begin
                if (s == 0) begin
                    if (wrap) begin ns = full; cy = 1'b1; nlim = 1'b0; end
                    else nlim = 1'b1;
                end else begin
                    ns = s - 1; nlim = 1'b0; ex = (s == 1);
                end
            end
        end
    endfunction

    function automatic logic [18:0] pack(input int s, input bit cy, input bit ex, input bit lim);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10), cy, ex, lim};
    endfunction

    task automatic step(input bit tk, input bit pz, input bit dr, input bit al,
                        input logic [1:0] sel, input logic [3:0] val);
        int ns;
        bit nlim, cy, ex;
        @(posedge clk);
        #1;
        tick = tk; paused = pz; dir = dr; adj_load = al; adj_sel = sel; adj_val = val;
        for (int i = 0; i < 2; i++) begin
            model_step(ms[i], mlim[i], mtm_of[i], wrap_of[i], tk, pz, dr, al, sel, val, ns, nlim, cy, ex);
            ms[i] = ns;
            mlim[i] = nlim;
            if (i == 0) q_w.push_back(pack(ns, cy, ex, nlim));
            else q_s.push_back(pack(ns, cy, ex, nlim));
        end
    endtask

    task automatic preset(input int mm, input int ss);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'(mm / 10));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'(mm % 10));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'(ss / 10));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'(ss % 10));
    endtask

    task automatic drain();
        int n;
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        n = 0;
        while ((q_w.size() > 0 || q_s.size() > 0) && n < 10) begin
            @(posedge clk);
            n++;
        end
        #4;
        checks++;
        if (q_w.size() > 0 || q_s.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q_w.size() + q_s.size());
        end
    endtask

    task automatic check_zero(input string name);
        checks += 2;
        if ({w_ml, w_mr, w_sl, w_sr, w_cy, w_ex, w_lim} !== 19'd0) begin
            failures++;
            $display("FAIL %s_wrap act=%h required=0", name, {w_ml, w_mr, w_sl, w_sr, w_cy, w_ex, w_lim});
        end
        if ({s_ml, s_mr, s_sl, s_sr, s_cy, s_ex, s_lim} !== 19'd0) begin
            failures++;
            $display("FAIL %s_sat act=%h required=0", name, {s_ml, s_mr, s_sl, s_sr, s_cy, s_ex, s_lim});
        end
    endtask

    initial begin : monitor
        logic [18:0] ew, es, aw, as_;
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            if (q_w.size() > 0 && q_s.size() > 0) begin
                ew = q_w.pop_front();
                es = q_s.pop_front();
                #3;
                aw  = {w_ml, w_mr, w_sl, w_sr, w_cy, w_ex, w_lim};
                as_ = {s_ml, s_mr, s_sl, s_sr, s_cy, s_ex, s_lim};
                checks += 2;
                if (aw !== ew) begin
                    failures++;
                    $display("FAIL wrap_dut step=%0d act=%h required=%h", n, aw, ew);
                end
                if (as_ !== es) begin
                    failures++;
                    $display("FAIL sat_dut step=%0d act=%h required=%h", n, as_, es);
                end
                n++;
            end
        end
    end

    initial begin : stimulus
        bit d;
        for (int i = 0; i < 2; i++) begin ms[i] = 0; mlim[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Range ends from 00:00: wrap goes to full scale, saturate holds.
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);

        if (ADJ) begin
            preset(59, 59);
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
            preset(10, 0);
            step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
            preset(0, 1);
            step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
            step(1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 4'd7);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd9);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd6);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd15);
            preset(37, 42);
        end else begin
            repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            step(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'd7);
        end

        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);

        // Long up run drives the saturating instance into its full-scale hold.
        repeat (1805) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

        d = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 49) == 0) d = ~d;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3, d,
                 $urandom_range(0, 24) < 2, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        drain();

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin ms[i] = 0; mlim[i] = 1'b0; end

        for (int k = 0; k < 30; k++)
            step($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b0, 2'd0, 4'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised successor of the stopwatch MM:SS counter. It counts four BCD digits up or down on a single-cycle `tick` strobe, with run-time digit adjust, a configurable minutes-tens limit, and selectable wrap or saturate at the ends of the range. It sits between the tick prescaler and the seven-segment display mux, and drives the display digits directly.

## Interface
- `MIN_TENS_MAX`, default 5: maximum minutes-tens digit, legal 1..9. Full-scale value is `MIN_TENS_MAX`9:59.
- `WRAP`, default 1: 1 wraps at the range ends; 0 saturates and holds.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `tick`  in  1  one-cycle count strobe from the prescaler.
- `paused`  in  1  when high, `tick` is ignored.
- `dir`  in  1  0 = count up, 1 = count down; sampled on each accepted tick.
- `adj_load`  in  1  one-cycle strobe that writes `adj_val` into the digit selected by `adj_sel`.
- `adj_sel`  in  2  selects the digit: 0 `min_l`, 1 `min_r`, 2 `sec_l`, 3 `sec_r`.
- `adj_val`  in  4  BCD value for the adjust write.
- `min_l`, `min_r`, `sec_l`, `sec_r`  out  4 each  BCD digits, registered.
- `carry_out`  out  1  one-cycle pulse when the count wraps in either direction.
- `expired`  out  1  one-cycle pulse when a down-count lands on 00:00.
- `at_limit`  out  1  level; high while the count is held at a range end in saturate mode.

## Operation
- Reset value of every output is 0: digits read 00:00, and all flags are low.
- Priority each cycle: `rst`, then `adj_load`, then an accepted tick. An accepted tick is `tick & !paused`.
- If `adj_load` and a tick occur in the same cycle, the tick is dropped.
- Digit maxima: `sec_r` 9, `sec_l` 5, `min_r` 9, `min_l` `MIN_TENS_MAX`.

**Up count**
- `sec_r` increments.
- On 9 it goes to 0 and carries into `sec_l`.
- `sec_l` on 5 goes to 0 and carries into `min_r`.
- `min_r` on 9 goes to 0 and carries into `min_l`.
- Carries ripple within the same cycle; one tick advances the count exactly one second.

**Down count**
- Mirror of up count: a digit at 0 borrows, reloads with its maximum, and decrements the next digit.

**Range ends**
- Up from full-scale:
  - `WRAP`=1: go to 00:00 and pulse `carry_out`.
  - `WRAP`=0: hold at full-scale and keep `at_limit` high.
- Down from 00:00:
  - `WRAP`=1: go to full-scale and pulse `carry_out`.
  - `WRAP`=0: hold at 00:00 and keep `at_limit` high.
- `at_limit` clears on the next adjust or on any tick that moves the count.
- `expired` pulses only on the transition 00:01 to 00:00 with `dir`=1. It never pulses when the count is already held at 00:00 or after an adjust.

**Adjust**
- Writing a value greater than the digit maximum stores the digit maximum. Example: `adj_val`=8 with `adj_sel`=2 stores 5.
- Adjust never generates `carry_out` or `expired`.

**Invariant**
- Every digit stays a legal BCD value at or below its maximum at all times.

## Timing
- Outputs are registered: a tick in cycle n is visible after the rising edge that ends cycle n. Latency is 1 cycle.
- `carry_out` and `expired` assert on the same edge as the digit update and last exactly 1 cycle.
- Back-to-back ticks on consecutive cycles each advance the count; no lost ticks.
- `rst` asserted mid-cascade returns to 00:00 with no partial carry.
- After `rst` deasserts, the first edge is a normal cycle.
- `paused` and `dir` are level inputs taking effect on the same edge at which they are sampled.

## Configuration
- `BCD_TIME_COUNTER_ADJUST_EN` defined:
  - The adjust logic is built as described above.
- Not defined:
  - `adj_load`, `adj_sel` and `adj_val` remain ports but are ignored.
  - Digits change only on reset or an accepted tick.
  - The clamp logic is removed.

## Test plan
- Up rollover, `MIN_TENS_MAX`=5, `WRAP`=1: preset 59:59, `dir`=0, one tick -> 00:00 next cycle; `carry_out` high 1 cycle; `expired` low.
- Down borrow chain: preset 10:00, `dir`=1, one tick -> 09:59. Preset 00:01, tick -> 00:00 with `expired` pulsed 1 cycle.
- Saturate, `WRAP`=0: at 00:00 with `dir`=1, 3 ticks -> stays 00:00; `at_limit`=1; no `expired` or `carry_out`. Switch to `dir`=0, tick -> 00:01; `at_limit`=0.
- Pause and priority: `paused`=1 with 5 ticks -> no change. `adj_load` with `adj_sel`=3, `adj_val`=7 in the same cycle as a tick -> `sec_r`=7 and the tick is dropped.
- Clamp, macro defined, `MIN_TENS_MAX`=2: `adj_sel`=0, `adj_val`=9 -> `min_l`=2. `adj_sel`=2, `adj_val`=6 -> `sec_l`=5.
- Async reset: assert `rst` between clock edges while at 37:42 -> all digits read 0 before the next edge. With the macro undefined, `adj_load` pulses leave the count unchanged.
